// File: rtl/aes_pkg.sv
// aes_pkg: shared constants and helpers for the iterative AES-128 datapath.
//   SBOX        - forward S-box, index 0 at the top of the packed array
//   RCON        - round constants, RCON[1..10] used, other slots zero
//   aes_fsm_e   - sequencer state encoding (2-bit)
//   AES_BLOCK_W - block / key width
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } aes_fsm_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Padded to 16 entries so a 4-bit round counter never indexes out of range.
  localparam logic [0:15][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round_step.sv
// aes_round_step: one combinational AES-128 round plus the matching key step.
//   i_state - current cipher state (byte 0 at [127:120], column-major)
//   i_rkey  - previous round key
//   i_rcon  - round constant for this round
//   i_last  - final round: MixColumns is bypassed
//   o_state - state after SubBytes/ShiftRows/(MixColumns)/AddRoundKey
//   o_rkey  - next round key, also the key added into o_state
module aes_round_step
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] i_state,
  input  logic [AES_BLOCK_W-1:0] i_rkey,
  input  logic [7:0]             i_rcon,
  input  logic                   i_last,
  output logic [AES_BLOCK_W-1:0] o_state,
  output logic [AES_BLOCK_W-1:0] o_rkey
);

  logic [31:0] w_w3;
  logic [31:0] w_temp;
  logic [31:0] w_k0, w_k1, w_k2, w_k3;

  // Key schedule: SubWord(RotWord(w3)) ^ rcon feeds a running XOR chain.
  assign w_w3   = i_rkey[31:0];
  assign w_temp = {SBOX[w_w3[23:16]] ^ i_rcon, SBOX[w_w3[15:8]],
                   SBOX[w_w3[7:0]], SBOX[w_w3[31:24]]};
  assign w_k0   = i_rkey[127:96] ^ w_temp;
  assign w_k1   = i_rkey[95:64]  ^ w_k0;
  assign w_k2   = i_rkey[63:32]  ^ w_k1;
  assign w_k3   = i_rkey[31:0]   ^ w_k2;
  assign o_rkey = {w_k0, w_k1, w_k2, w_k3};

  for (genvar c = 0; c < 4; c++) begin : g_col
    // ShiftRows: row r of output column c comes from column (c+r)%4.
    localparam int I0 = 4 * ((c + 0) % 4) + 0;
    localparam int I1 = 4 * ((c + 1) % 4) + 1;
    localparam int I2 = 4 * ((c + 2) % 4) + 2;
    localparam int I3 = 4 * ((c + 3) % 4) + 3;

    logic [7:0]  w_s0, w_s1, w_s2, w_s3;
    logic [31:0] w_mix;

    assign w_s0 = SBOX[i_state[127-8*I0 -: 8]];
    assign w_s1 = SBOX[i_state[127-8*I1 -: 8]];
    assign w_s2 = SBOX[i_state[127-8*I2 -: 8]];
    assign w_s3 = SBOX[i_state[127-8*I3 -: 8]];

    assign w_mix = {
      xtime(w_s0) ^ xtime(w_s1) ^ w_s1 ^ w_s2 ^ w_s3,
      w_s0 ^ xtime(w_s1) ^ xtime(w_s2) ^ w_s2 ^ w_s3,
      w_s0 ^ w_s1 ^ xtime(w_s2) ^ xtime(w_s3) ^ w_s3,
      xtime(w_s0) ^ w_s0 ^ w_s1 ^ w_s2 ^ xtime(w_s3)
    };

    assign o_state[127-32*c -: 32] =
      (i_last ? {w_s0, w_s1, w_s2, w_s3} : w_mix) ^ o_rkey[127-32*c -: 32];
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: iterative AES-128 encryptor, one round per clock on a
// single shared round datapath; round keys are derived on the fly.
//   clk, rst  - clock, synchronous active-high reset
//   start     - encrypt request, taken when ready=1
//   key_in    - cipher key, sampled on the accept edge
//   data_in   - plaintext, sampled on the accept edge
//   ready     - a start would be accepted this cycle
//   busy      - rounds in progress
//   done      - data_out holds a fresh ciphertext
//   out_ready - consumer handshake (only with AES_SEQ_BACKPRESSURE_EN)
//   data_out  - ciphertext, byte 0 at [127:120]
// Build option AES_SEQ_BACKPRESSURE_EN: when defined, DONE waits for
// out_ready; otherwise done is a one-cycle pulse and DONE accepts a new start.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [AES_BLOCK_W-1:0] key_in,
  input  logic [AES_BLOCK_W-1:0] data_in,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
`ifdef AES_SEQ_BACKPRESSURE_EN
  input  logic                   out_ready,
`endif
  output logic [AES_BLOCK_W-1:0] data_out
);

  if (NR != 10) begin : g_bad_nr
    $error("aes_round_sequencer: NR must be 10 for AES-128");
  end

  aes_fsm_e               r_fsm;
  logic [AES_BLOCK_W-1:0] r_state;
  logic [AES_BLOCK_W-1:0] r_rkey;
  logic [3:0]             r_rnd;
  logic [AES_BLOCK_W-1:0] r_dout;
  logic                   r_ready;
  logic                   r_busy;
  logic                   r_done;

  logic [AES_BLOCK_W-1:0] w_nstate;
  logic [AES_BLOCK_W-1:0] w_nkey;
  logic [7:0]             w_rcon;
  logic                   w_last;
  logic                   w_accept;

  // r_rnd holds 10 in FINAL, so one table lookup covers both round kinds.
  assign w_rcon   = RCON[r_rnd];
  assign w_last   = (r_fsm == ST_FINAL);
  // r_ready is only set in states that may take a new block.
  assign w_accept = start && r_ready;

  aes_round_step u_step (
    .i_state (r_state),
    .i_rkey  (r_rkey),
    .i_rcon  (w_rcon),
    .i_last  (w_last),
    .o_state (w_nstate),
    .o_rkey  (w_nkey)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm   <= ST_IDLE;
      r_state <= '0;
      r_rkey  <= '0;
      r_rnd   <= '0;
      r_dout  <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (w_accept) begin
      // Initial AddRoundKey happens on the accept edge.
      r_fsm   <= ST_ROUND;
      r_state <= data_in ^ key_in;
      r_rkey  <= key_in;
      r_rnd   <= 4'd1;
      r_ready <= 1'b0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      case (r_fsm)
        ST_ROUND: begin
          r_state <= w_nstate;
          r_rkey  <= w_nkey;
          r_rnd   <= r_rnd + 4'd1;
          if (r_rnd == 4'(NR - 1)) r_fsm <= ST_FINAL;
        end
        ST_FINAL: begin
          r_state <= w_nstate;
          r_rkey  <= w_nkey;
          r_dout  <= w_nstate;
          r_fsm   <= ST_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
`ifdef AES_SEQ_BACKPRESSURE_EN
          r_ready <= 1'b0;
`else
          r_ready <= 1'b1;
`endif
        end
        ST_DONE: begin
`ifdef AES_SEQ_BACKPRESSURE_EN
          if (out_ready) begin
            r_fsm   <= ST_IDLE;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
          end
`else
          r_fsm  <= ST_IDLE;
          r_done <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign ready    = r_ready;
  assign busy     = r_busy;
  assign done     = r_done;
  assign data_out = r_dout;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: FIPS-197 vectors, control-path corner cases and
// randomized blocks checked against a byte-array AES-128 reference model
// whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_round_sequencer;

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] RK1_B = 128'ha0fafe1788542cb123a339392a6c7605;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [127:0] key_in, data_in, data_out;
  logic         ready, busy, done;
`ifdef AES_SEQ_BACKPRESSURE_EN
  logic         out_ready;
`endif

  int          n_chk = 0;
  int          n_err = 0;
  logic [7:0]  sb [256];

  always #5 clk = ~clk;

  aes_round_sequencer #(.NR(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .data_in  (data_in),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
`ifdef AES_SEQ_BACKPRESSURE_EN
    .out_ready(out_ready),
`endif
    .data_out (data_out)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Textbook AES-128: full key expansion up front, then ten rounds on bytes.
  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
    logic [7:0]   w [176];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   tmp [4];
    logic [7:0]   rc, x;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      w[i] = k[127-8*i -: 8];
      s[i] = p[127-8*i -: 8];
    end
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
      if (i % 4 == 0) begin
        x = tmp[0];
        tmp[0] = sb[tmp[1]] ^ rc;
        tmp[1] = sb[tmp[2]];
        tmp[2] = sb[tmp[3]];
        tmp[3] = sb[x];
        rc = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] ^= w[i];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end
      end else begin
        s = t;
      end
      for (int i = 0; i < 16; i++) s[i] ^= w[16*r+i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Present a request for one cycle; inputs are scrambled afterwards since
  // they must not be re-sampled.
  task automatic go(input logic [127:0] k, input logic [127:0] p);
    start = 1'b1; key_in = k; data_in = p;
    step();
    start = 1'b0; key_in = rnd128(); data_in = rnd128();
  endtask

  // Called at cycle n0 after the accept edge; waits for done (bounded),
  // checks latency, result and busy/done behaviour.  rk1 captures the
  // internal round key one cycle after the first ROUND edge.
  task automatic wait_done(input string tag, input logic [127:0] exp, input bit noise,
                           input int n0, output logic [127:0] rk1);
    int n;
    bit seen, ctl_ok;
    n = n0; seen = 1'b0; ctl_ok = 1'b1; rk1 = '0;
    while (n <= 30 && !seen) begin
      if (n == 2) rk1 = dut.r_rkey;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (!busy || ready) ctl_ok = 1'b0;
        if (noise && n <= 10) begin
          start = 1'($urandom_range(0, 1)); key_in = rnd128(); data_in = rnd128();
        end
        step();
        n++;
      end
    end
    start = 1'b0;
    chk({tag, "_latency"}, n, 11);
    chk({tag, "_ct"}, data_out, exp);
    chk({tag, "_busy_while_running"}, ctl_ok, 1'b1);
    chk({tag, "_busy_done_excl"}, {busy, done}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [127:0] rk, k, p0, hold_dout;
    logic [7:0]   inv, y;
    bit           hold_ok;
    int           gap;

    for (int xi = 0; xi < 256; xi++) begin
      inv = 8'h00;
      for (int yi = 1; yi < 256; yi++)
        if (gmul(8'(xi), 8'(yi)) == 8'h01) inv = 8'(yi);
      y = inv;
      for (int r = 0; r < 4; r++) begin
        y = rotl1(y);
        inv ^= y;
      end
      sb[xi] = inv ^ 8'h63;
    end

    rst = 1'b1; start = 1'b0; key_in = '0; data_in = '0;
`ifdef AES_SEQ_BACKPRESSURE_EN
    out_ready = 1'b1;
`endif
    step(); step();
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dout", data_out, '0);
    rst = 1'b0;
    step();

    // FIPS-197 C.1
    go(K_C1, P_C1);
    wait_done("c1", CT_C1, 1'b0, 1, rk);
    step();
    chk("c1_done_pulse", done, 1'b0);
    chk("c1_ready_after", ready, 1'b1);

    // FIPS-197 B, plus the round-1 key
    go(K_B, P_B);
    wait_done("fipsB", CT_B, 1'b0, 1, rk);
    chk("fipsB_rkey1", rk, RK1_B);
    step();

    // start held for five cycles with changing data: only the first block counts
    k = rnd128(); p0 = rnd128();
    start = 1'b1; key_in = k; data_in = p0;
    step();
    hold_ok = 1'b1;
    for (int i = 1; i < 5; i++) begin
      if (!busy) hold_ok = 1'b0;
      key_in = rnd128(); data_in = rnd128();
      step();
    end
    if (!busy) hold_ok = 1'b0;
    start = 1'b0;
    wait_done("hold", aes_ref(k, p0), 1'b0, 5, rk);
    chk("hold_busy", hold_ok, 1'b1);
    step();

    // abort in the 5th ROUND cycle
    go(rnd128(), rnd128());
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_ready", ready, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_dout", data_out, '0);
    go(K_C1, P_C1);
    wait_done("abort_c1", CT_C1, 1'b0, 1, rk);
    step();

    // rst on the same edge as start drops the request
    rst = 1'b1; start = 1'b1; key_in = K_B; data_in = P_B;
    step();
    rst = 1'b0; start = 1'b0;
    step();
    chk("rst_start_busy", busy, 1'b0);
    chk("rst_start_ready", ready, 1'b1);
    chk("rst_start_dout", data_out, '0);

`ifdef AES_SEQ_BACKPRESSURE_EN
    // consumer stalls for four cycles
    out_ready = 1'b0;
    go(K_C1, P_C1);
    wait_done("bp_c1", CT_C1, 1'b0, 1, rk);
    hold_dout = data_out;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_hold_done", done, 1'b1);
      chk("bp_hold_dout", data_out, hold_dout);
      chk("bp_hold_ready", ready, 1'b0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_done", done, 1'b0);
    chk("bp_release_ready", ready, 1'b1);
`else
    // back-to-back: second start in the DONE cycle
    go(K_C1, P_C1);
    wait_done("b2b_c1", CT_C1, 1'b0, 1, rk);
    hold_dout = data_out;
    chk("b2b_ready_in_done", ready, 1'b1);
    go(K_B, P_B);
    chk("b2b_busy_again", busy, 1'b1);
    wait_done("b2b_b", CT_B, 1'b0, 1, rk);
    chk("b2b_first_ct", hold_dout, CT_C1);
`endif

    // randomized blocks with spurious starts while busy
    for (int t = 0; t < 12; t++) begin
`ifdef AES_SEQ_BACKPRESSURE_EN
      gap = $urandom_range(1, 3);
`else
      gap = $urandom_range(0, 2);
`endif
      for (int g = 0; g < gap; g++) step();
      k = rnd128(); p0 = rnd128();
      go(k, p0);
      wait_done("rand", aes_ref(k, p0), 1'b1, 1, rk);
    end
    step(); step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
